// File: rtl/pwm_dac_pkg.sv
// pwm_dac_pkg: shared offset-binary sample conventions for the sine table and pwm_dac
package pwm_dac_pkg;
   localparam int W_DEFAULT = 8;
   localparam int MIDSCALE = 1 << (W_DEFAULT - 1);
   // zero level of an offset-binary sample of width w
   function automatic int midscale(input int w);
      return 1 << (w - 1);
   endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: free-running prescaler, tick on the all-ones count
module tick_divider
   import pwm_dac_pkg::*;
#(
   parameter int N = 1
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   logic [N-1:0] pre;
   always_ff @(posedge clk or posedge rst)
      if (rst) pre <= '0;
      else pre <= pre + 1'b1;
   assign tick = &pre;
endmodule

// File: rtl/pwm_dac.sv
// pwm_dac: double-buffered offset-binary sample to single-bit PWM with frame-rate handshake
module pwm_dac
   import pwm_dac_pkg::*;
#(
   parameter int W = W_DEFAULT,
   parameter int N_DIVIDE = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] sample,
   input  logic         sample_valid,
   output logic         sample_ready,
   output logic         pwm_out,
   output logic         period_start,
   output logic         underrun,
   output logic [W-1:0] duty
);
   localparam logic [W-1:0] MID = W'(midscale(W));
   logic tick, boundary, acc, pend_full;
   logic [W-1:0] cnt, pend, active;
   if (N_DIVIDE > 0) begin : g_div
      tick_divider #(.N(N_DIVIDE)) u_div (.clk(clk), .rst(rst), .tick(tick));
   end else begin : g_nodiv
      assign tick = 1'b1;
   end
   assign sample_ready = ~pend_full;
   assign acc = sample_valid & sample_ready;
   assign boundary = tick & (&cnt);
   assign duty = active;
   // a sample arriving exactly on an empty-buffer boundary bypasses pend
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         cnt <= '0;
         pend <= '0;
         pend_full <= 1'b0;
         active <= MID;
         pwm_out <= 1'b0;
         period_start <= 1'b0;
         underrun <= 1'b0;
      end else begin
         if (tick) cnt <= cnt + 1'b1;
         pwm_out <= cnt < active;
         period_start <= boundary;
         underrun <= boundary & ~pend_full & ~acc;
         if (boundary & pend_full) begin
            active <= pend;
            pend_full <= 1'b0;
         end else if (boundary & acc) begin
            active <= sample;
         end else if (acc) begin
            pend <= sample;
            pend_full <= 1'b1;
         end
      end
endmodule

// File: tb/tb_pwm_dac.sv
// tb_pwm_dac: directed checks of pwm_dac (N_DIVIDE 0 and 2) against a frame-level model
module tb_pwm_dac;
   logic clk = 1'b0, rst = 1'b1, sample_valid = 1'b0;
   logic [7:0] sample = 8'h00;
   logic [1:0] ready, pwm, ps, ur;
   logic [1:0][7:0] duty;
   int vec = 0, bad = 0;

   pwm_dac #(.W(8), .N_DIVIDE(0)) dut0 (
      .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
      .sample_ready(ready[0]), .pwm_out(pwm[0]), .period_start(ps[0]),
      .underrun(ur[0]), .duty(duty[0]));
   pwm_dac #(.W(8), .N_DIVIDE(2)) dut2 (
      .clk(clk), .rst(rst), .sample(sample), .sample_valid(sample_valid),
      .sample_ready(ready[1]), .pwm_out(pwm[1]), .period_start(ps[1]),
      .underrun(ur[1]), .duty(duty[1]));

   always #5 clk = ~clk;

   // model: elapsed clocks since reset give the counter; accepted samples queue for the next frame
   for (genvar g = 0; g < 2; g++) begin : m
      localparam int ND = (g == 0) ? 0 : 2;
      int unsigned cyc;
      logic [7:0] q[$];
      logic [7:0] e_act;
      logic e_pwm, e_ps, e_ur, e_rdy;
      int c;
      bit bnd;
      int hi, len, urc, fr, last_hi, last_len, last_ur;
      always @(posedge clk or posedge rst)
         if (rst) begin
            cyc = 0;
            q.delete();
            e_act = 8'h80;
            e_pwm = 1'b0;
            e_ps = 1'b0;
            e_ur = 1'b0;
            e_rdy = 1'b1;
         end else begin
            c = int'((cyc >> ND) % 256);
            bnd = ((cyc + 1) % (1 << ND) == 0) && c == 255;
            e_pwm = c < int'(e_act);
            if (sample_valid && q.size() == 0) q.push_back(sample);
            e_ps = bnd;
            e_ur = bnd && q.size() == 0;
            if (bnd && q.size() != 0) e_act = q.pop_front();
            e_rdy = q.size() == 0;
            cyc++;
         end
      // per-frame measurement window: from the cycle after period_start up to the next one
      always @(negedge clk)
         if (rst) begin
            hi = 0; len = 0; urc = 0; fr = 0;
         end else begin
            hi += int'(pwm[g]);
            len++;
            urc += int'(ur[g]);
            if (ps[g]) begin
               last_hi = hi; last_len = len; last_ur = urc;
               hi = 0; len = 0; urc = 0;
               fr++;
            end
         end
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", n, act, exp, $time);
      end
   endtask

   always @(negedge clk)
      if (!rst) begin
         chk("pwm0", 32'(pwm[0]), 32'(m[0].e_pwm));
         chk("ps0", 32'(ps[0]), 32'(m[0].e_ps));
         chk("ur0", 32'(ur[0]), 32'(m[0].e_ur));
         chk("rdy0", 32'(ready[0]), 32'(m[0].e_rdy));
         chk("duty0", 32'(duty[0]), 32'(m[0].e_act));
         chk("pwm2", 32'(pwm[1]), 32'(m[1].e_pwm));
         chk("ps2", 32'(ps[1]), 32'(m[1].e_ps));
         chk("ur2", 32'(ur[1]), 32'(m[1].e_ur));
         chk("rdy2", 32'(ready[1]), 32'(m[1].e_rdy));
         chk("duty2", 32'(duty[1]), 32'(m[1].e_act));
      end

   function automatic int fr_of(input int k);
      return (k == 0) ? m[0].fr : m[1].fr;
   endfunction

   function automatic int cnt_of(input int k);
      return (k == 0) ? int'(m[0].cyc % 256) : int'((m[1].cyc >> 2) % 256);
   endfunction

   task automatic step;
      @(negedge clk);
      #1;
   endtask

   task automatic timeout(input string n);
      vec++;
      bad++;
      $display("FAIL %s: got timeout want event at %0t", n, $time);
   endtask

   task automatic wait_cnt(input int k, input int v);
      int n = 0;
      while (cnt_of(k) != v && n < 3000) begin
         step;
         n++;
      end
      if (n >= 3000) timeout("wait_cnt");
   endtask

   task automatic wait_frame(input int k);
      int f = fr_of(k);
      int n = 0;
      while (fr_of(k) == f && n < 3000) begin
         step;
         n++;
      end
      if (n >= 3000) timeout("wait_frame");
   endtask

   task automatic send(input logic [7:0] v, input int at);
      wait_cnt(0, at);
      sample = v;
      sample_valid = 1'b1;
      step;
      sample_valid = 1'b0;
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      wait_frame(0);
      wait_frame(0);
      chk("idle_hi", m[0].last_hi, 128);
      chk("idle_len", m[0].last_len, 256);
      chk("idle_ur", m[0].last_ur, 1);
      chk("idle_duty", 32'(duty[0]), 32'h80);
      send(8'h40, 10);
      wait_frame(0);
      chk("load_prev_hi", m[0].last_hi, 128);
      chk("load_prev_ur", m[0].last_ur, 0);
      wait_frame(0);
      chk("load_hi", m[0].last_hi, 64);
      chk("load_duty", 32'(duty[0]), 32'h40);
      send(8'h00, 10);
      wait_frame(0);
      send(8'hFF, 10);
      wait_frame(0);
      chk("ext_zero_hi", m[0].last_hi, 0);
      wait_frame(0);
      chk("ext_full_hi", m[0].last_hi, 255);
      chk("ext_full_lo", m[0].last_len - m[0].last_hi, 1);
      wait_cnt(0, 50);
      sample = 8'h10;
      sample_valid = 1'b1;
      step;
      sample = 8'h20;
      chk("bp_ready_low", 32'(ready[0]), 0);
      n = 0;
      while (!ready[0] && n < 600) begin
         step;
         n++;
      end
      if (n >= 600) timeout("bp_ready");
      chk("bp_ready_cnt", cnt_of(0), 0);
      step;
      sample_valid = 1'b0;
      wait_frame(0);
      chk("bp_first_hi", m[0].last_hi, 16);
      wait_frame(0);
      chk("bp_second_hi", m[0].last_hi, 32);
      wait_cnt(0, 255);
      sample = 8'hC0;
      sample_valid = 1'b1;
      chk("sim_ready_pre", 32'(ready[0]), 1);
      step;
      sample_valid = 1'b0;
      chk("sim_ready_post", 32'(ready[0]), 1);
      chk("sim_prev_hi", m[0].last_hi, 32);
      chk("sim_ur", m[0].last_ur, 0);
      wait_frame(0);
      chk("sim_hi", m[0].last_hi, 192);
      wait_cnt(1, 90);
      sample = 8'h80;
      sample_valid = 1'b1;
      step;
      sample_valid = 1'b0;
      wait_cnt(1, 100);
      rst = 1'b1;
      #1;
      chk("rst_duty2", 32'(duty[1]), 32'h80);
      chk("rst_duty0", 32'(duty[0]), 32'h80);
      chk("rst_pwm2", 32'(pwm[1]), 0);
      chk("rst_ready2", 32'(ready[1]), 1);
      chk("rst_ps2", 32'(ps[1]), 0);
      chk("rst_ur2", 32'(ur[1]), 0);
      step;
      step;
      rst = 1'b0;
      wait_frame(1);
      chk("pre_len", m[1].last_len, 1024);
      chk("pre_hi", m[1].last_hi, 512);
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish by %0t", $time);
      $fatal(1, "watchdog");
   end
endmodule
